// File: rtl/reg_bank_xfer.sv
// Sixteen-entry register bank with an external write port and a register-to-register
// transfer engine that steers the external bus mux via Sel and writes its outBus back.
module reg_bank_xfer #(
    parameter int WIDTH  = 16,
    parameter int SETTLE = 1
) (
    input  logic             Clk,
    input  logic             Resetn,
    input  logic             WrEn,
    input  logic [3:0]       WrAddr,
    input  logic [WIDTH-1:0] WrData,
    input  logic             XferReq,
    input  logic [3:0]       XferSrc,
    input  logic [3:0]       XferDst,
    input  logic [WIDTH-1:0] outBus,
    output logic [3:0]       Sel,
    output logic             XferBusy,
    output logic             XferDone,
    output logic [WIDTH-1:0] outR0,
    output logic [WIDTH-1:0] outR1,
    output logic [WIDTH-1:0] outR2,
    output logic [WIDTH-1:0] outR3,
    output logic [WIDTH-1:0] outR4,
    output logic [WIDTH-1:0] outR5,
    output logic [WIDTH-1:0] outR6,
    output logic [WIDTH-1:0] outR7,
    output logic [WIDTH-1:0] outR8,
    output logic [WIDTH-1:0] outR9,
    output logic [WIDTH-1:0] outR10,
    output logic [WIDTH-1:0] outR11,
    output logic [WIDTH-1:0] outR12,
    output logic [WIDTH-1:0] outR13,
    output logic [WIDTH-1:0] outR14,
    output logic [WIDTH-1:0] outR15
);

    typedef enum logic [1:0] {IDLE, SEL, LOAD, DONE} xferState_e;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    xferState_e       state;
    xferState_e       stateNext;
    logic [3:0]       count;
    logic [3:0]       countNext;
    logic [3:0]       selNext;
    logic [3:0]       dstReg;
    logic [3:0]       dstNext;
    logic             loadEn;
    logic [WIDTH-1:0] regFile [16];

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            state  <= IDLE;
            count  <= '0;
            Sel    <= '0;
            dstReg <= '0;
        end else begin
            state  <= stateNext;
            count  <= countNext;
            Sel    <= selNext;
            dstReg <= dstNext;
        end
    end

    // Sel doubles as the latched source index; it only moves when a request is accepted.
    always_comb begin
        stateNext = state;
        countNext = count;
        selNext   = Sel;
        dstNext   = dstReg;
        loadEn    = 1'b0;
        XferBusy  = 1'b0;
        XferDone  = 1'b0;
        case (state)
            IDLE: begin
                if (XferReq) begin
                    selNext   = XferSrc;
                    dstNext   = XferDst;
                    countNext = '0;
                    stateNext = SEL;
                end
            end
            SEL: begin
                XferBusy  = 1'b1;
                countNext = count + 4'd1;
                if (count == SETTLE_LAST) begin
                    stateNext = LOAD;
                end
            end
            LOAD: begin
                XferBusy  = 1'b1;
                loadEn    = 1'b1;
                stateNext = DONE;
            end
            DONE: begin
                XferDone  = 1'b1;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // The transfer write is issued last so it overrides an external write to the same register.
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            for (int i = 0; i < 16; i++) begin
                regFile[i] <= '0;
            end
        end else begin
            if (WrEn) begin
                regFile[WrAddr] <= WrData;
            end
            if (loadEn) begin
                regFile[dstReg] <= outBus;
            end
        end
    end

    assign outR0  = regFile[0];
    assign outR1  = regFile[1];
    assign outR2  = regFile[2];
    assign outR3  = regFile[3];
    assign outR4  = regFile[4];
    assign outR5  = regFile[5];
    assign outR6  = regFile[6];
    assign outR7  = regFile[7];
    assign outR8  = regFile[8];
    assign outR9  = regFile[9];
    assign outR10 = regFile[10];
    assign outR11 = regFile[11];
    assign outR12 = regFile[12];
    assign outR13 = regFile[13];
    assign outR14 = regFile[14];
    assign outR15 = regFile[15];

endmodule

// File: tb/tb_reg_bank_xfer.sv
// Bench for reg_bank_xfer: a cycle-level reference model queues expected transfer completions,
// and a negedge monitor compares registers, handshakes and completions against it.
module tb_reg_bank_xfer;

    localparam int SETTLE = 3;

    logic        Clk = 1'b0;
    logic        Resetn;
    logic        WrEn;
    logic [3:0]  WrAddr;
    logic [15:0] WrData;
    logic        XferReq;
    logic [3:0]  XferSrc;
    logic [3:0]  XferDst;
    logic [15:0] outBus;
    logic [3:0]  Sel;
    logic        XferBusy;
    logic        XferDone;
    logic [15:0] outR [16];

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0]  dst;
        logic [15:0] value;
        int          doneEdge;
    } expect_t;

    expect_t     expQ [$];
    logic [15:0] model [16];
    logic [3:0]  mSel;
    logic [3:0]  mSrc;
    logic [3:0]  mDst;
    bit          active;
    int          reqEdge;
    int          cyc;

    reg_bank_xfer #(.WIDTH(16), .SETTLE(SETTLE)) dut (
        .Clk(Clk), .Resetn(Resetn), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
        .XferReq(XferReq), .XferSrc(XferSrc), .XferDst(XferDst), .outBus(outBus),
        .Sel(Sel), .XferBusy(XferBusy), .XferDone(XferDone),
        .outR0(outR[0]),   .outR1(outR[1]),   .outR2(outR[2]),   .outR3(outR[3]),
        .outR4(outR[4]),   .outR5(outR[5]),   .outR6(outR[6]),   .outR7(outR[7]),
        .outR8(outR[8]),   .outR9(outR[9]),   .outR10(outR[10]), .outR11(outR[11]),
        .outR12(outR[12]), .outR13(outR[13]), .outR14(outR[14]), .outR15(outR[15])
    );

    // The neighbouring 16:1 bus mux.
    assign outBus = outR[Sel];

    always #5 Clk = ~Clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic we, input logic [3:0] wa, input logic [15:0] wd,
                                 input logic rq, input logic [3:0] s, input logic [3:0] d);
        WrEn    = we;
        WrAddr  = wa;
        WrData  = wd;
        XferReq = rq;
        XferSrc = s;
        XferDst = d;
        @(posedge Clk);
        #1;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 4'd0);
        end
    endtask

    // Reference model: a transfer accepted at edge N copies the pre-edge source value into the
    // destination at edge N+SETTLE+1, beating any same-edge external write to that destination.
    always @(posedge Clk or negedge Resetn) begin
        logic [15:0] nextModel [16];
        if (!Resetn) begin
            cyc    = 0;
            active = 1'b0;
            mSel   = 4'd0;
            for (int i = 0; i < 16; i++) model[i] = 16'd0;
            expQ.delete();
        end else begin
            cyc++;
            nextModel = model;
            if (WrEn) nextModel[WrAddr] = WrData;
            if (active && cyc == reqEdge + SETTLE + 1) begin
                nextModel[mDst] = model[mSrc];
                expQ.push_back('{dst: mDst, value: model[mSrc], doneEdge: cyc});
            end
            if (!active && XferReq) begin
                active  = 1'b1;
                reqEdge = cyc;
                mSrc    = XferSrc;
                mDst    = XferDst;
                mSel    = XferSrc;
            end else if (active && cyc == reqEdge + SETTLE + 2) begin
                active = 1'b0;
            end
            model = nextModel;
        end
    end

    // Monitor: pops a completion whenever the DUT pulses XferDone.
    always @(negedge Clk) begin
        bit      expBusy;
        bit      expDone;
        expect_t e;
        if (Resetn) begin
            expBusy = active && cyc >= reqEdge && cyc < reqEdge + SETTLE + 1;
            expDone = active && cyc == reqEdge + SETTLE + 1;
            checkOutput("busy", {31'd0, XferBusy}, {31'd0, expBusy});
            checkOutput("done", {31'd0, XferDone}, {31'd0, expDone});
            checkOutput("sel", {28'd0, Sel}, {28'd0, mSel});
            for (int i = 0; i < 16; i++) begin
                checkOutput($sformatf("reg%0d", i), {16'd0, outR[i]}, {16'd0, model[i]});
            end
            if (XferDone) begin
                if (expQ.size() == 0) begin
                    checkOutput("done-unexpected", 32'd1, 32'd0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("done-cycle", cyc, e.doneEdge);
                    checkOutput("xfer-value", {16'd0, outR[e.dst]}, {16'd0, e.value});
                end
            end
            if (expQ.size() > 0 && expQ[0].doneEdge < cyc) begin
                e = expQ.pop_front();
                checkOutput("done-missing", 32'd0, 32'd1);
            end
        end
    end

    initial begin
        Resetn = 1'b0;
        WrEn = 1'b0; WrAddr = '0; WrData = '0;
        XferReq = 1'b0; XferSrc = '0; XferDst = '0;
        repeat (2) @(posedge Clk);
        #1;
        checkOutput("rst-sel", {28'd0, Sel}, 32'd0);
        checkOutput("rst-busy", {31'd0, XferBusy}, 32'd0);
        checkOutput("rst-done", {31'd0, XferDone}, 32'd0);
        Resetn = 1'b1;
        idleCycles(2);

        // External write, then a plain transfer R3 -> R9.
        applyStimulus(1'b1, 4'd5, 16'hBEEF, 1'b0, 4'd0, 4'd0);
        applyStimulus(1'b1, 4'd3, 16'h1234, 1'b0, 4'd0, 4'd0);
        applyStimulus(1'b0, 4'd0, 16'd0, 1'b1, 4'd3, 4'd9);
        // Second request while busy must be ignored.
        applyStimulus(1'b0, 4'd0, 16'd0, 1'b1, 4'd1, 4'd2);
        idleCycles(SETTLE + 4);

        // Collision: external write to dst in the LOAD cycle loses.
        applyStimulus(1'b0, 4'd0, 16'd0, 1'b1, 4'd3, 4'd7);
        idleCycles(SETTLE);
        applyStimulus(1'b1, 4'd7, 16'hFFFF, 1'b0, 4'd0, 4'd0);
        idleCycles(4);

        // Self copy.
        applyStimulus(1'b1, 4'd4, 16'h00A5, 1'b0, 4'd0, 4'd0);
        applyStimulus(1'b0, 4'd0, 16'd0, 1'b1, 4'd4, 4'd4);
        idleCycles(SETTLE + 4);

        // Source rewritten during SEL: the new value is copied.
        applyStimulus(1'b0, 4'd0, 16'd0, 1'b1, 4'd6, 4'd10);
        applyStimulus(1'b1, 4'd6, 16'hCAFE, 1'b0, 4'd0, 4'd0);
        idleCycles(SETTLE + 4);

        // Held request restarts right after DONE.
        for (int i = 0; i < 2 * (SETTLE + 3) + 1; i++) begin
            applyStimulus(1'b0, 4'd0, 16'd0, 1'b1, 4'd5, 4'd11);
        end
        idleCycles(SETTLE + 4);

        // Reset mid-SEL aborts the transfer.
        applyStimulus(1'b1, 4'd12, 16'h5A5A, 1'b0, 4'd0, 4'd0);
        applyStimulus(1'b0, 4'd0, 16'd0, 1'b1, 4'd12, 4'd13);
        #2;
        Resetn = 1'b0;
        #1;
        checkOutput("abort-busy", {31'd0, XferBusy}, 32'd0);
        checkOutput("abort-done", {31'd0, XferDone}, 32'd0);
        checkOutput("abort-sel", {28'd0, Sel}, 32'd0);
        checkOutput("abort-r12", {16'd0, outR[12]}, 32'd0);
        checkOutput("abort-r5", {16'd0, outR[5]}, 32'd0);
        XferReq = 1'b0;
        @(posedge Clk);
        #1;
        Resetn = 1'b1;
        idleCycles(SETTLE + 4);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 2) == 0, 4'($urandom), 16'($urandom),
                          $urandom_range(0, 3) == 0, 4'($urandom), 4'($urandom));
        end
        idleCycles(SETTLE + 6);
        checkOutput("queue-drained", expQ.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
